// File: rtl/lsu.sv
// RV32I load/store unit: single outstanding access, byte-lane formatting.
// Define LSU_MISALIGN_CHECK_EN to fault misaligned halfword/word accesses.
module lsu #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        mem_valid,
    input  logic        mem_ready,
    output logic [31:0] mem_addr,
    output logic        mem_wen,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wmask,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_RESP
    } state_t;

    localparam bit          TO_EN  = (TIMEOUT_CYCLES != 0);
    localparam logic [31:0] TO_LIM = 32'(TIMEOUT_CYCLES - 1);

    state_t      state, state_d;
    logic        we_q;
    logic [2:0]  f3_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;
    logic [31:0] cnt_q, cnt_d;

    logic        hs;
    logic        op_legal;
    logic        misalign;
    logic        to_hit;
    logic [31:0] byte_sh;
    logic [7:0]  ld_b;
    logic [15:0] ld_h;
    logic [31:0] ld_data;
    logic [3:0]  st_mask;
    logic [31:0] st_data;
    logic        in_req;

    assign hs = req_valid && req_ready;

    always_comb begin
        op_legal = 1'b0;
        case (req_funct3)
            3'b000, 3'b001, 3'b010: op_legal = 1'b1;
            3'b100, 3'b101:         op_legal = !req_we;
            default:                op_legal = 1'b0;
        endcase
    end

`ifdef LSU_MISALIGN_CHECK_EN
    always_comb begin
        misalign = 1'b0;
        case (req_funct3[1:0])
            2'b01:   misalign = req_addr[0];
            2'b10:   misalign = (req_addr[1:0] != 2'b00);
            default: misalign = 1'b0;
        endcase
    end
`else
    assign misalign = 1'b0;
`endif

    // Memory handshakes are checked first so they win over a same-cycle timeout.
    assign to_hit = TO_EN && (cnt_q == TO_LIM);

    assign byte_sh = mem_rdata >> {addr_q[1:0], 3'b000};
    assign ld_b    = byte_sh[7:0];
    assign ld_h    = addr_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];

    always_comb begin
        ld_data = mem_rdata;
        case (f3_q)
            3'b000:  ld_data = {{24{ld_b[7]}}, ld_b};
            3'b001:  ld_data = {{16{ld_h[15]}}, ld_h};
            3'b100:  ld_data = {24'd0, ld_b};
            3'b101:  ld_data = {16'd0, ld_h};
            default: ld_data = mem_rdata;
        endcase
    end

    always_comb begin
        st_mask = 4'b1111;
        st_data = wdata_q;
        case (f3_q[1:0])
            2'b00: begin
                st_mask = 4'b0001 << addr_q[1:0];
                st_data = {4{wdata_q[7:0]}};
            end
            2'b01: begin
                st_mask = 4'b0011 << {addr_q[1], 1'b0};
                st_data = {2{wdata_q[15:0]}};
            end
            default: begin
                st_mask = 4'b1111;
                st_data = wdata_q;
            end
        endcase
    end

    always_comb begin
        state_d = state;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        unique case (state)
            S_IDLE: begin
                if (req_valid) begin
                    rdata_d = '0;
                    err_d   = 1'b0;
                    if (!op_legal || misalign) begin
                        state_d = S_RESP;
                        err_d   = 1'b1;
                    end else begin
                        state_d = S_REQ;
                        cnt_d   = '0;
                    end
                end
            end
            S_REQ: begin
                cnt_d = cnt_q + 32'd1;
                if (mem_ready) begin
                    state_d = we_q ? S_RESP : S_WAIT;
                end else if (to_hit) begin
                    state_d = S_RESP;
                    err_d   = 1'b1;
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q + 32'd1;
                if (mem_rvalid) begin
                    state_d = S_RESP;
                    rdata_d = ld_data;
                end else if (to_hit) begin
                    state_d = S_RESP;
                    err_d   = 1'b1;
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state   <= S_IDLE;
            cnt_q   <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            we_q    <= 1'b0;
            f3_q    <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state   <= state_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            if (hs) begin
                we_q    <= req_we;
                f3_q    <= req_funct3;
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
            end
        end
    end

    assign in_req     = (state == S_REQ);
    assign req_ready  = (state == S_IDLE);
    assign resp_valid = (state == S_RESP);
    assign resp_rdata = resp_valid ? rdata_q : '0;
    assign resp_err   = resp_valid && err_q;
    assign mem_valid  = in_req;
    assign mem_addr   = {addr_q[31:2], 2'b00};
    assign mem_wen    = in_req && we_q;
    assign mem_wmask  = (in_req && we_q) ? st_mask : 4'b0000;
    assign mem_wdata  = (in_req && we_q) ? st_data : '0;

endmodule
